// File: rtl/uart_tick_tx_if.sv
// Parallel-side handshake between a data source and the tick-paced UART transmitter.
interface uart_tick_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_busy;
  logic                  tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tick_tx.sv
// UART frame serializer paced by an external bit-period tick.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, 1-2 stop bits.
// cnt_clear restarts the external tick counter on acceptance so that every bit,
// the start bit included, lasts exactly one tick period.
module uart_tick_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  output logic            cnt_clear,
  output logic            tx_serial,
  uart_tick_tx_if.slave   host
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic          LAST_STOP = (STOP_BITS > 1);
  localparam logic          ODD       = (PARITY_ODD != 0);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  parity_q, parity_d;
  logic [BW-1:0]         bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  serial_q, serial_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept;

  // A start request is taken only while idle; the same condition restarts the counter.
  always_comb begin
    accept    = host.tx_start && (state_q == S_IDLE);
    cnt_clear = accept;
  end

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    serial_d   = serial_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        if (accept) begin
          shreg_d    = host.tx_data;
          parity_d   = (^host.tx_data) ^ ODD;
          serial_d   = 1'b0;
          busy_d     = 1'b1;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          serial_d  = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_BIT) begin
            if (HAS_PAR) begin
              serial_d = parity_q;
              state_d  = S_PARITY;
            end else begin
              serial_d   = 1'b1;
              stop_idx_d = 1'b0;
              state_d    = S_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            serial_d  = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          serial_d   = 1'b1;
          stop_idx_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_idx_q == LAST_STOP) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame and returns the line high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      serial_q   <= serial_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Drive ports from the registered copies.
  always_comb begin
    tx_serial    = serial_q;
    host.tx_busy = busy_q;
    host.tx_done = done_q;
  end

endmodule
